// File: rtl/rib_mem_slave_pkg.sv
// Shared constants, FSM state encoding and byte-lane helper for the RIB data-memory responder.
package rib_mem_slave_pkg;

   localparam logic RIB_REQ  = 1'b1;
   localparam logic RIB_NREQ = 1'b0;
   localparam logic RIB_ACK  = 1'b1;
   localparam logic RIB_NACK = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } rib_state_e;

   // Merge new_word into old_word on the lanes enabled by be.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/rib_sram_bank.sv
// Word-organised data RAM: byte-enable synchronous write, registered read with same-edge forwarding.
module rib_sram_bank
   import rib_mem_slave_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_be,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic          rd_clr,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem_r [DEPTH_WORDS];
   logic [31:0] rd_data_r;

   // Byte-lane write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem_r[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Read register; holds between reads, cleared for error responses
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_r <= 32'h0000_0000;
      end else if (rd_clr) begin
         rd_data_r <= 32'h0000_0000;
      end else if (rd_en) begin
         // a store completing on the same edge must be visible to the read
         if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_r <= lane_merge(mem_r[rd_addr], wr_data, wr_be);
         end else begin
            rd_data_r <= mem_r[rd_addr];
         end
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/rib_mem_slave.sv
// RIB bus responder: accepts MEM-stage load/store requests, inserts wait states,
// decodes the address window and answers with ack/err/rdata while holding the pipeline.
module rib_mem_slave
   import rib_mem_slave_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] rdata_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        hold_req_o
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
   localparam logic        HAS_WAIT  = (WAIT_CYCLES > 0);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   rib_state_e  state_r, state_nxt_s;
   logic [3:0]  cnt_r, cnt_nxt_s;
   logic        we_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  sel_r;
   logic        ack_r;
   logic        err_r;
   logic        accept_s;
   logic        hold_s;
   logic        up_we_s;
   logic [31:0] up_addr_s;
   logic        up_ok_s;
   logic        resp_nxt_s;
   logic        rd_en_s;
   logic        rd_clr_s;
   logic        wr_en_s;
   logic [31:0] rdata_s;

   function automatic logic in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return (off < SPAN);
   endfunction

   function automatic logic [AW-1:0] word_index(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return off[AW+1:2];
   endfunction

   // Next-state, wait counter, accept and hold decode
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      accept_s    = 1'b0;
      hold_s      = 1'b0;
      case (state_r)
         ST_IDLE, ST_RESP: begin
            accept_s = (req_i == RIB_REQ);
            // in RESP the stall only extends when wait states follow
            hold_s   = accept_s && ((state_r == ST_IDLE) || HAS_WAIT);
            if (accept_s) begin
               if (HAS_WAIT) begin
                  state_nxt_s = ST_WAIT;
                  cnt_nxt_s   = WAIT_LOAD;
               end else begin
                  state_nxt_s = ST_RESP;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            hold_s = 1'b1;
            if (cnt_r == 4'd0) begin
               state_nxt_s = ST_RESP;
            end else begin
               cnt_nxt_s = cnt_r - 4'd1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // RAM port control for the response about to be presented and the one completing now
   always_comb begin
      up_we_s    = 1'b0;
      up_addr_s  = 32'h0000_0000;
      if (state_r == ST_WAIT) begin
         up_we_s   = we_r;
         up_addr_s = addr_r;
      end else begin
         up_we_s   = we_i;
         up_addr_s = addr_i;
      end
      up_ok_s    = in_range(up_addr_s);
      resp_nxt_s = (state_nxt_s == ST_RESP);
      rd_en_s    = resp_nxt_s && !up_we_s && up_ok_s;
      rd_clr_s   = resp_nxt_s && !up_ok_s;
      wr_en_s    = (state_r == ST_RESP) && we_r && in_range(addr_r) && !rst;
   end

   // FSM state, wait counter and registered response flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         ack_r   <= RIB_NACK;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         ack_r   <= resp_nxt_s ? RIB_ACK : RIB_NACK;
         err_r   <= resp_nxt_s && !up_ok_s;
      end
   end

   // Request capture on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         we_r    <= 1'b0;
         addr_r  <= 32'h0000_0000;
         wdata_r <= 32'h0000_0000;
         sel_r   <= 4'h0;
      end else if (accept_s) begin
         we_r    <= we_i;
         addr_r  <= addr_i;
         wdata_r <= wdata_i;
         sel_r   <= sel_i;
      end
   end

   rib_sram_bank #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_s),
      .wr_addr (word_index(addr_r)),
      .wr_be   (sel_r),
      .wr_data (wdata_r),
      .rd_en   (rd_en_s),
      .rd_clr  (rd_clr_s),
      .rd_addr (word_index(up_addr_s)),
      .rd_data (rdata_s)
   );

   assign rdata_o    = rdata_s;
   assign ack_o      = ack_r;
   assign err_o      = err_r;
   assign hold_req_o = hold_s;

endmodule

// File: tb/tb_rib_mem_slave.sv
// Directed bench for rib_mem_slave: a WAIT_CYCLES=2 instance driven from a vector table,
// plus a WAIT_CYCLES=0 instance for back-to-back and same-edge store/load sequences.
module tb_rib_mem_slave;

   localparam logic [31:0] BASE = 32'h1000_0000;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic        exp_err;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst2, req2, we2, ack2, err2, hold2;
   logic [31:0] addr2, wdata2, rdata2;
   logic [3:0]  sel2;
   logic        rst0, req0, we0, ack0, err0, hold0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [3:0]  sel0;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs [12];

   always #5 clk = ~clk;

   rib_mem_slave #(.DEPTH_WORDS(4096), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) dut2 (
      .clk(clk), .rst(rst2), .req_i(req2), .we_i(we2), .addr_i(addr2), .wdata_i(wdata2),
      .sel_i(sel2), .rdata_o(rdata2), .ack_o(ack2), .err_o(err2), .hold_req_o(hold2));

   rib_mem_slave #(.DEPTH_WORDS(4096), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
      .clk(clk), .rst(rst0), .req_i(req0), .we_i(we0), .addr_i(addr0), .wdata_i(wdata0),
      .sel_i(sel0), .rdata_o(rdata0), .ack_o(ack0), .err_o(err0), .hold_req_o(hold0));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One isolated transaction on the WAIT_CYCLES=2 instance; entered and left at posedge+1.
   task automatic txn2(input vec_t v, input string tag);
      for (int c = 0; c < 5; c++) begin
         req2 = (c == 0); we2 = v.we; addr2 = v.addr; wdata2 = v.wdata; sel2 = v.sel;
         @(negedge clk);
         if (c < 3) begin
            check($sformatf("%s c%0d hold", tag, c), hold2, 32'd1);
            check($sformatf("%s c%0d ack", tag, c), ack2, 32'd0);
         end else if (c == 3) begin
            check($sformatf("%s ack", tag), ack2, 32'd1);
            check($sformatf("%s err", tag), err2, v.exp_err);
            check($sformatf("%s resp hold", tag), hold2, 32'd0);
            if (v.chk_rd) check($sformatf("%s rdata", tag), rdata2, v.exp_rd);
         end else begin
            check($sformatf("%s after ack", tag), ack2, 32'd0);
            check($sformatf("%s after err", tag), err2, 32'd0);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      rst2 = 1'b1; req2 = 1'b0; we2 = 1'b0; addr2 = 32'h0; wdata2 = 32'h0; sel2 = 4'h0;
      rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; sel0 = 4'h0;

      //          we    addr            wdata           sel      err   chk   rdata
      vecs[0]  = '{1'b1, 32'h1000_0014, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1, 32'h0000_0000};
      vecs[1]  = '{1'b1, 32'h1000_0008, 32'h1122_3344, 4'b1111, 1'b0, 1'b1, 32'h0000_0000};
      vecs[2]  = '{1'b0, 32'h1000_0014, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 32'h1000_0008, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b1, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 32'h1000_000A, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 32'h11BB_33DD};
      vecs[5]  = '{1'b0, 32'h1000_4000, 32'h0000_0000, 4'b0000, 1'b1, 1'b1, 32'h0000_0000};
      vecs[6]  = '{1'b1, 32'h1000_3FFC, 32'h0BAD_F00D, 4'b1111, 1'b0, 1'b1, 32'h0000_0000};
      vecs[7]  = '{1'b0, 32'h1000_3FFC, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 32'h0BAD_F00D};
      vecs[8]  = '{1'b1, 32'h0FFF_FFFC, 32'h1234_5678, 4'b1111, 1'b1, 1'b0, 32'h0000_0000};
      vecs[9]  = '{1'b1, 32'h1000_0008, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
      vecs[10] = '{1'b0, 32'h1000_0008, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 32'h11BB_33DD};
      vecs[11] = '{1'b0, 32'h1000_3FFC, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 32'h0BAD_F00D};

      repeat (3) @(posedge clk);
      #1; rst2 = 1'b0; rst0 = 1'b0;
      @(negedge clk);
      check("reset ack2", ack2, 32'd0);
      check("reset err2", err2, 32'd0);
      check("reset rdata2", rdata2, 32'h0);
      check("reset hold2", hold2, 32'd0);
      check("reset ack0", ack0, 32'd0);
      check("reset rdata0", rdata0, 32'h0);
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) txn2(vecs[i], $sformatf("vec%0d", i));

      // Reset during the wait states of a store: no ack, outputs cleared, word untouched.
      req2 = 1'b1; we2 = 1'b1; addr2 = 32'h1000_0014; wdata2 = 32'hFFFF_FFFF; sel2 = 4'b1111;
      @(posedge clk); #1;
      req2 = 1'b0; rst2 = 1'b1;
      @(posedge clk); #1;
      rst2 = 1'b0;
      for (int c = 2; c < 7; c++) begin
         @(negedge clk);
         check($sformatf("rstmid c%0d ack", c), ack2, 32'd0);
         if (c == 2) begin
            check("rstmid err", err2, 32'd0);
            check("rstmid rdata", rdata2, 32'h0);
            check("rstmid hold", hold2, 32'd0);
         end
         @(posedge clk); #1;
      end
      v = '{1'b0, 32'h1000_0014, 32'h0, 4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF};
      txn2(v, "rstmid reload");

      // Zero wait states: four back-to-back stores, then four back-to-back loads.
      for (int c = 0; c < 5; c++) begin
         req0 = (c < 4); we0 = 1'b1; addr0 = BASE + 32'(4 * c);
         wdata0 = 32'hA000_0000 + 32'(c); sel0 = 4'b1111;
         @(negedge clk);
         check($sformatf("b2b st c%0d hold", c), hold0, (c == 0) ? 32'd1 : 32'd0);
         check($sformatf("b2b st c%0d ack", c), ack0, (c == 0) ? 32'd0 : 32'd1);
         @(posedge clk); #1;
      end
      for (int c = 0; c < 6; c++) begin
         req0 = (c < 4); we0 = 1'b0; addr0 = BASE + 32'(4 * c); wdata0 = 32'h0; sel0 = 4'h0;
         @(negedge clk);
         check($sformatf("b2b ld c%0d hold", c), hold0, (c == 0) ? 32'd1 : 32'd0);
         check($sformatf("b2b ld c%0d ack", c), ack0, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
         if (c >= 1 && c <= 4) begin
            check($sformatf("b2b ld c%0d rdata", c), rdata0, 32'hA000_0000 + 32'(c - 1));
            check($sformatf("b2b ld c%0d err", c), err0, 32'd0);
         end
         @(posedge clk); #1;
      end

      // Store, partial store, then load of the same word on consecutive cycles.
      for (int c = 0; c < 5; c++) begin
         req0 = (c < 3); we0 = (c < 2); addr0 = 32'h1000_001C;
         wdata0 = (c == 0) ? 32'h1111_1111 : 32'hAABB_CCDD;
         sel0 = (c == 0) ? 4'b1111 : 4'b1010;
         @(negedge clk);
         check($sformatf("stld c%0d ack", c), ack0, (c >= 1 && c <= 3) ? 32'd1 : 32'd0);
         if (c == 3) check("stld rdata", rdata0, 32'hAA11_CC11);
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rib_mem_slave.md
Name: rib_mem_slave

Overview:
- Responder end of the core's RIB data-bus protocol: accepts load/store requests issued by the MEM stage and returns load data or a store acknowledge.
- Backs a word-organised on-chip data RAM with byte-lane writes and a configurable wait-state count.
- Drives a hold request to ctrl so the pipeline stalls until the access completes.
- Load data returned here is the data the MEM stage selects when its request flag equals `RIB_REQ.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit RAM words; power of two.
- WAIT_CYCLES, 2: extra cycles between request accept and the response; 0 to 15.
- BASE_ADDR, 32'h1000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  1  request valid (`RIB_REQ = 1)
- we_i  in  1  1 = store, 0 = load
- addr_i  in  32  byte address
- wdata_i  in  32  store data
- sel_i  in  4  byte-lane enables; bit n selects wdata_i[8n+7:8n]
- rdata_o  out  32  load data
- ack_o  out  1  one-cycle response pulse
- err_o  out  1  address out of range; valid with ack_o
- hold_req_o  out  1  stall request to ctrl

Behaviour:
- Single clock, clk. Reset rst is synchronous and active-high.
- FSM has three states: IDLE, WAIT, RESP.
- Reset values: state = IDLE, ack_o = 0, err_o = 0, rdata_o = 0, wait counter = 0. RAM contents are not cleared.
- Accept: req_i = 1 sampled at a clock edge while state is IDLE or RESP. Latch we_i, addr_i, wdata_i and sel_i into internal registers. req_i is ignored in WAIT.
- Transitions on accept:
  - WAIT_CYCLES > 0: go to WAIT and load counter = WAIT_CYCLES-1.
  - WAIT_CYCLES = 0: go to RESP.
- WAIT: decrement counter each cycle; when counter = 0, go to RESP. WAIT lasts exactly WAIT_CYCLES cycles.
- RESP:
  - ack_o = 1 for exactly this cycle.
  - Next state is RESP again if a new req_i is accepted this cycle, otherwise IDLE.
  - Back-to-back throughput is one access per WAIT_CYCLES+1 cycles.
- Latency: request accepted at the edge ending cycle T produces ack_o in cycle T+WAIT_CYCLES+1.
- Address decode:
  - Word index = (addr - BASE_ADDR) >> 2, using the latched address.
  - addr[1:0] is ignored; no misalignment fault.
  - In range when addr - BASE_ADDR < DEPTH_WORDS*4 (unsigned compare).
- Out of range:
  - err_o = 1 in the RESP cycle, no RAM write, rdata_o = 0.
  - err_o = 0 in every other cycle.
- Load: rdata_o = RAM[index], registered so it is valid in the RESP cycle. rdata_o holds its value until the next load response. A store does not change rdata_o.
- Store:
  - Only lanes with sel_i bit = 1 are written, at the edge ending RESP.
  - sel_i = 0 gives an ack with no write.
  - Store-then-load to the same word returns the new data.
- hold_req_o is combinational: 1 when (state = IDLE and req_i = 1), or state = WAIT, or (state = RESP and req_i = 1 and WAIT_CYCLES > 0). Otherwise 0.
- Reset mid-transaction:
  - FSM returns to IDLE; no ack_o is issued.
  - A pending store is dropped, leaving the RAM unmodified.
- Simultaneous RESP and new req_i: the old ack and write complete, and the new request is latched in the same edge.

Decomposition:
- defines.v gains the following shared constants:
  - `RIB_REQ and `RIB_NREQ
  - `RIB_ACK and `RIB_NACK
  - FSM state encodings: IDLE 2'b00, WAIT 2'b01, RESP 2'b10
- One sub-module, rib_sram_bank, holds the storage:
  - Parameter DEPTH_WORDS.
  - Synchronous single-port RAM with a 4-bit byte write enable and a registered read.
  - Must infer block RAM.
- rib_mem_slave keeps the FSM, counter, decode and error logic.

Test Plan:
- Load, WAIT_CYCLES = 2: preload word 5 = 32'hDEADBEEF; req at cycle 0, addr 32'h1000_0014, we = 0 -> ack_o = 1 in cycle 3, rdata_o = 32'hDEADBEEF, err_o = 0, hold_req_o = 1 in cycles 0-2.
- Byte-lane store: word 2 = 32'h11223344; store addr 32'h1000_0008, wdata 32'hAABBCCDD, sel 4'b0101 -> later load of word 2 returns 32'h11BB33DD.
- Out of range: load addr 32'h1000_4000 (DEPTH_WORDS = 4096) -> ack_o with err_o = 1, rdata_o = 0; RAM unchanged.
- Back-to-back, WAIT_CYCLES = 0: req held high for 4 cycles with loads of words 0-3 -> ack_o high in cycles 1-4 with data in order; hold_req_o = 1 only in cycle 0.
- Reset mid-operation: store accepted in cycle 0, rst = 1 in cycle 1 -> no ack_o; outputs return to reset values; word keeps its old value.
- Store then load, same word, consecutive requests -> load returns the stored value.
